// File: rtl/ram_dump_tx_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg -- shared types and constants for the capture-RAM dump engine.
//
// Contents:
//   state_t    dump FSM state encoding (HEADER exists only when the optional
//              header is built in, macro RAM_DUMP_TX_HEADER_EN)
//   HDR_SYNC0  first sync byte of the optional dump header (0xA5)
//   HDR_SYNC1  second sync byte of the optional dump header (0x5A)
//   HDR_BYTES  number of header bytes (two sync bytes + 16-bit sample count)
// -----------------------------------------------------------------------------
package la_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
`ifdef RAM_DUMP_TX_HEADER_EN
        ,
        HEADER
`endif
    } state_t;

    localparam logic [7:0] HDR_SYNC0 = 8'hA5;
    localparam logic [7:0] HDR_SYNC1 = 8'h5A;
    localparam int         HDR_BYTES = 4;

endpackage : la_pkg

// File: rtl/ram_dump_tx_if.sv
// -----------------------------------------------------------------------------
// ram_dump_tx_if -- capture-RAM read port plus the byte stream to the UART.
//
// Signals:
//   rd_addr        capture RAM read address (engine -> RAM)
//   rd_data        capture RAM read data, RD_LAT cycles after rd_addr
//   tx_data        byte to transmit (engine -> UART)
//   tx_data_valid  tx_data holds a valid byte
//   tx_data_ack    one-cycle accept pulse from the UART
//
// Byte handshake: a byte is transferred on every rising clk edge where
// tx_data_valid and tx_data_ack are both high. Once raised, tx_data_valid
// stays high and tx_data stays constant until that transfer (or an abort);
// tx_data_ack while tx_data_valid is low has no effect.
//
// Modports:
//   master  the dump engine
//   slave   the RAM / UART side
// -----------------------------------------------------------------------------
interface ram_dump_tx_if #(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 8
);

    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic [7:0]          tx_data;
    logic                tx_data_valid;
    logic                tx_data_ack;

    modport master (
        output rd_addr,
        input  rd_data,
        output tx_data,
        output tx_data_valid,
        input  tx_data_ack
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ack
    );

endinterface : ram_dump_tx_if

// File: rtl/ram_dump_tx_sample_serializer.sv
// -----------------------------------------------------------------------------
// ram_dump_tx_sample_serializer -- splits one SAMPLE_W word into bytes.
//
// A load captures the word and presents byte 0 with byte_valid high. Each
// accepted byte (ack while byte_valid) shifts the word right by 8 and presents
// the next byte; the ack of the last byte drops byte_valid. clear drops
// byte_valid at once (abort).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        abandon the current word
//   load         capture load_data and start presenting it
//   load_data    SAMPLE_W word to serialize
//   ack          byte accepted (only meaningful while byte_valid)
//   byte_out     current byte, LSB-first order
//   byte_valid   byte_out is valid
//   last_byte    byte_out is the final byte of the word
// -----------------------------------------------------------------------------
module ram_dump_tx_sample_serializer #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] load_data,
    input  logic                ack,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    output logic                last_byte
);

    localparam int BYTES_PER_SAMPLE = SAMPLE_W / 8;
    localparam int IDX_W = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);

    logic [SAMPLE_W-1:0] shift_reg;
    logic [SAMPLE_W-1:0] shift_next;
    logic [IDX_W-1:0]    byte_idx;
    logic                valid_q;

    // A single-byte word never shifts; avoid a zero-width slice in that case.
    if (SAMPLE_W > 8) begin : g_shift
        assign shift_next = {8'h00, shift_reg[SAMPLE_W-1:8]};
    end else begin : g_no_shift
        assign shift_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            byte_idx  <= '0;
            valid_q   <= 1'b0;
        end else if (clear) begin
            valid_q   <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            byte_idx  <= '0;
            valid_q   <= 1'b1;
        end else if (ack && valid_q) begin
            if (byte_idx == LAST_IDX) begin
                valid_q   <= 1'b0;
            end else begin
                shift_reg <= shift_next;
                byte_idx  <= byte_idx + IDX_W'(1);
            end
        end
    end

    assign byte_out   = shift_reg[7:0];
    assign byte_valid = valid_q;
    assign last_byte  = (byte_idx == LAST_IDX);

endmodule : ram_dump_tx_sample_serializer

// File: rtl/ram_dump_tx.sv
// -----------------------------------------------------------------------------
// ram_dump_tx -- capture-RAM dump engine.
//
// When grant_txd is high in IDLE, reads dump_len samples (0 = whole RAM)
// starting at start_addr, wrapping past the top address, and streams each
// sample LSB-first as bytes over the tx byte handshake. done_txd pulses for
// one cycle after the last byte; dropping grant_txd mid-dump aborts silently.
//
// Optional build macro RAM_DUMP_TX_HEADER_EN: the dump is preceded by a
// 4-byte header A5, 5A, sample count low byte, sample count high byte.
//
// Parameters:
//   ADDR_W    capture RAM address width, 2..15
//   SAMPLE_W  RAM word width, multiple of 8, at most 64
//   RD_LAT    RAM read latency rd_addr -> rd_data in cycles, 1..3
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   grant_txd    transmitter granted (level)
//   start_addr   first sample address, sampled on start
//   dump_len     sample count, 0 = 2^ADDR_W, sampled on start
//   bus          RAM read port and byte stream (master side)
//   done_txd     one-cycle completion pulse
//   busy         high whenever the FSM is not in IDLE
//   dbg_state    current FSM state for observation
// -----------------------------------------------------------------------------
module ram_dump_tx
    import la_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 8,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant_txd,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   dump_len,
    ram_dump_tx_if.master     bus,
    output logic              done_txd,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int BYTES_PER_SAMPLE = SAMPLE_W / 8;
    // Sample count used when dump_len is 0: the whole RAM.
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      LAT_LAST   = 2'(RD_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;

    logic              ser_clear;
    logic              ser_load;
    logic              ser_ack;
    logic [7:0]        ser_byte;
    logic              ser_valid;
    logic              ser_last;

    logic              tx_valid;
    logic              ack_seen;

`ifdef RAM_DUMP_TX_HEADER_EN
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [15:0]       hdr_count;
    logic [7:0]        hdr_byte;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            lat_cnt_q   <= '0;
`ifdef RAM_DUMP_TX_HEADER_EN
            hdr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            lat_cnt_q   <= lat_cnt_d;
`ifdef RAM_DUMP_TX_HEADER_EN
            hdr_idx_q   <= hdr_idx_d;
`endif
        end
    end

    // An ack only counts while a byte is actually offered.
    assign ack_seen = bus.tx_data_ack && tx_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        lat_cnt_d   = lat_cnt_q;
        ser_clear   = 1'b0;
        ser_load    = 1'b0;
        ser_ack     = 1'b0;
`ifdef RAM_DUMP_TX_HEADER_EN
        hdr_idx_d   = hdr_idx_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_txd) begin
                    rd_addr_d   = start_addr;
                    remaining_d = (dump_len == '0) ? FULL_COUNT : dump_len;
                    lat_cnt_d   = '0;
`ifdef RAM_DUMP_TX_HEADER_EN
                    hdr_idx_d   = '0;
                    state_d     = HEADER;
`else
                    state_d     = FETCH;
`endif
                end
            end

`ifdef RAM_DUMP_TX_HEADER_EN
            HEADER: begin
                if (!grant_txd) begin
                    state_d = IDLE;
                end else if (ack_seen) begin
                    if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                        lat_cnt_d = '0;
                        state_d   = FETCH;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
`endif

            // rd_addr has been stable since entry, so after RD_LAT edges the
            // RAM output reflects it; capture it one edge later.
            FETCH: begin
                if (!grant_txd) begin
                    state_d = IDLE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    ser_load = 1'b1;
                    state_d  = SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            SEND: begin
                if (!grant_txd) begin
                    ser_clear = 1'b1;
                    state_d   = IDLE;
                end else if (ack_seen) begin
                    ser_ack = 1'b1;
                    if (ser_last) begin
                        remaining_d = remaining_q - (ADDR_W + 1)'(1);
                        if (remaining_q == (ADDR_W + 1)'(1)) begin
                            state_d = DONE;
                        end else begin
                            // Natural ADDR_W-bit overflow gives the wrap to 0.
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            lat_cnt_d = '0;
                            state_d   = FETCH;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Byte serializer
    // -------------------------------------------------------------------------
    ram_dump_tx_sample_serializer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (ser_clear),
        .load       (ser_load),
        .load_data  (bus.rd_data),
        .ack        (ser_ack),
        .byte_out   (ser_byte),
        .byte_valid (ser_valid),
        .last_byte  (ser_last)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
`ifdef RAM_DUMP_TX_HEADER_EN
    // While in HEADER, remaining_q still holds the full sample count.
    assign hdr_count = 16'(remaining_q);

    always_comb begin
        hdr_byte = HDR_SYNC0;
        case (hdr_idx_q)
            2'd0:    hdr_byte = HDR_SYNC0;
            2'd1:    hdr_byte = HDR_SYNC1;
            2'd2:    hdr_byte = hdr_count[7:0];
            default: hdr_byte = hdr_count[15:8];
        endcase
    end

    assign tx_valid    = ser_valid || (state_q == HEADER);
    assign bus.tx_data = (state_q == HEADER) ? hdr_byte : ser_byte;
`else
    assign tx_valid    = ser_valid;
    assign bus.tx_data = ser_byte;
`endif

    assign bus.tx_data_valid = tx_valid;
    assign bus.rd_addr       = rd_addr_q;
    assign done_txd          = (state_q == DONE);
    assign busy              = (state_q != IDLE);
    assign dbg_state         = state_q;

    // Byte count per dump depends only on remaining and BYTES_PER_SAMPLE; the
    // serializer owns the per-sample byte index.
    logic unused_bps;
    assign unused_bps = (BYTES_PER_SAMPLE == 0);

endmodule : ram_dump_tx

// File: tb/tb_ram_dump_tx.sv
// -----------------------------------------------------------------------------
// tb_ram_dump_tx -- self-checking bench for ram_dump_tx.
//
// Two engines share clock, reset and the stimulus signals; `sel` picks which
// one is driven and observed:
//   sel 0: defaults (ADDR_W 10, SAMPLE_W 8, RD_LAT 1)
//   sel 1: ADDR_W 4, SAMPLE_W 16, RD_LAT 2
// The expected byte stream is derived from the RAM contents, start address and
// length (plus the header when RAM_DUMP_TX_HEADER_EN is defined).
// -----------------------------------------------------------------------------
module tb_ram_dump_tx;
    import la_pkg::*;

    localparam int AW_A  = 10;
    localparam int SW_A  = 8;
    localparam int LAT_A = 1;
    localparam int AW_B  = 4;
    localparam int SW_B  = 16;
    localparam int LAT_B = 2;
    localparam int BUDGET = 8000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          sel = 0;
    logic        grant = 1'b0;
    logic        ack = 1'b0;
    logic [14:0] start = '0;
    logic [15:0] len = '0;

    logic [7:0] exp_q[$];

    // ---------------- DUTs and RAM models ----------------
    ram_dump_tx_if #(.ADDR_W(AW_A), .SAMPLE_W(SW_A)) bus_a ();
    ram_dump_tx_if #(.ADDR_W(AW_B), .SAMPLE_W(SW_B)) bus_b ();

    logic   grant_a, grant_b, done_a, done_b, busy_a, busy_b;
    state_t st_a, st_b;

    assign grant_a           = grant && (sel == 0);
    assign grant_b           = grant && (sel == 1);
    assign bus_a.tx_data_ack = ack && (sel == 0);
    assign bus_b.tx_data_ack = ack && (sel == 1);

    ram_dump_tx #(.ADDR_W(AW_A), .SAMPLE_W(SW_A), .RD_LAT(LAT_A)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_txd  (grant_a),
        .start_addr (start[AW_A-1:0]),
        .dump_len   (len[AW_A:0]),
        .bus        (bus_a),
        .done_txd   (done_a),
        .busy       (busy_a),
        .dbg_state  (st_a)
    );

    ram_dump_tx #(.ADDR_W(AW_B), .SAMPLE_W(SW_B), .RD_LAT(LAT_B)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_txd  (grant_b),
        .start_addr (start[AW_B-1:0]),
        .dump_len   (len[AW_B:0]),
        .bus        (bus_b),
        .done_txd   (done_b),
        .busy       (busy_b),
        .dbg_state  (st_b)
    );

    logic [7:0]  ram_a[1 << AW_A];
    logic [15:0] ram_b[1 << AW_B];
    logic [15:0] b_q1;

    always_ff @(posedge clk) begin
        bus_a.rd_data <= ram_a[bus_a.rd_addr];
        b_q1          <= ram_b[bus_b.rd_addr];
        bus_b.rd_data <= b_q1;
    end

    // observed signals of the selected engine
    logic [7:0]  o_data;
    logic [14:0] o_addr;
    logic        o_valid, o_done, o_busy;
    state_t      o_st;

    always_comb begin
        if (sel == 0) begin
            o_data  = bus_a.tx_data;
            o_valid = bus_a.tx_data_valid;
            o_addr  = 15'(bus_a.rd_addr);
            o_done  = done_a;
            o_busy  = busy_a;
            o_st    = st_a;
        end else begin
            o_data  = bus_b.tx_data;
            o_valid = bus_b.tx_data_valid;
            o_addr  = 15'(bus_b.rd_addr);
            o_done  = done_b;
            o_busy  = busy_b;
            o_st    = st_b;
        end
    end

    // ---------------- reference model ----------------
    function automatic int cur_aw();
        return (sel == 0) ? AW_A : AW_B;
    endfunction

    function automatic int cur_lat();
        return (sel == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic build_expected(input int start_v, input int len_v, output int n);
        int aw, bps, addr;
        logic [63:0] word;
        aw  = cur_aw();
        bps = (sel == 0) ? SW_A / 8 : SW_B / 8;
        n   = (len_v == 0) ? (1 << aw) : len_v;
        exp_q.delete();
`ifdef RAM_DUMP_TX_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(n));
        exp_q.push_back(8'(n >> 8));
`endif
        for (int k = 0; k < n; k++) begin
            addr = (start_v + k) % (1 << aw);
            word = (sel == 0) ? 64'(ram_a[addr]) : 64'(ram_b[addr]);
            for (int b = 0; b < bps; b++) exp_q.push_back(8'(word >> (8 * b)));
        end
    endtask

    // ---------------- driver + scoreboard for one dump ----------------
    // gap < 0 picks a random ack delay per byte; abort_after >= 0 drops grant
    // right after that many accepted bytes.
    task automatic run_dump(input string name, input int start_v, input int len_v,
                            input int gap, input int abort_after);
        int n, cycles, first_valid, acks, done_cnt, done_post, post;
        int wait_cnt, cur_gap, unstable, prints, exp_first, exp_last_addr;
        bit aborted, abort_pending, finished, was_valid;
        logic [7:0] last_data, exp_b;

        build_expected(start_v, len_v, n);
        exp_last_addr = (start_v + n - 1) % (1 << cur_aw());
`ifdef RAM_DUMP_TX_HEADER_EN
        exp_first = 1;
`else
        exp_first = cur_lat() + 2;
`endif
        cycles = 0; first_valid = -1; acks = 0; done_cnt = 0; done_post = 0;
        post = 0; wait_cnt = 0; unstable = 0; prints = 0;
        aborted = 0; abort_pending = 0; finished = 0; was_valid = 0;
        last_data = '0;
        cur_gap = (gap < 0) ? int'($urandom_range(0, 3)) : gap;

        @(negedge clk);
        start = 15'(start_v);
        len   = 16'(len_v);
        grant = 1'b1;
        ack   = 1'b0;

        while (!finished && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_grant: got %b expected 1", name, o_busy);
                end
            end
            if (aborted) begin
                post++;
                ack = 1'b0;
                if (post == 1) begin
                    checks++;
                    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s abort_outputs: got valid %b busy %b expected 0 0",
                                 name, o_valid, o_busy);
                    end
                end
                if (o_done) done_cnt++;
                if (post == 6) finished = 1;
            end else if (abort_pending) begin
                grant = 1'b0;
                ack = 1'b0;
                aborted = 1;
                abort_pending = 0;
            end else begin
                if (o_valid && first_valid < 0) first_valid = cycles;
                if (was_valid && !ack && o_valid && o_data !== last_data) unstable++;
                was_valid = o_valid;
                last_data = o_data;
                if (o_done) begin
                    done_cnt++;
                    if (done_cnt == 1) begin
                        checks++;
                        if (exp_q.size() != 0) begin
                            errors++;
                            $display("FAIL %s done_early: got %0d bytes left expected 0",
                                     name, exp_q.size());
                        end
                    end
                    grant = 1'b0;
                end else if (done_cnt > 0) begin
                    done_post++;
                    if (done_post >= 4) finished = 1;
                end
                if (ack) begin
                    ack = 1'b0;
                end else if (grant && o_valid) begin
                    if (wait_cnt >= cur_gap) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL %s extra_byte: got %02h expected none", name, o_data);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (o_data !== exp_b) begin
                                errors++;
                                if (prints < 8)
                                    $display("FAIL %s byte %0d: got %02h expected %02h",
                                             name, acks, o_data, exp_b);
                                prints++;
                            end
                        end
                        ack = 1'b1;
                        acks++;
                        wait_cnt = 0;
                        cur_gap = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                        if (abort_after >= 0 && acks == abort_after) abort_pending = 1;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
        ack = 1'b0;
        grant = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: got %0d cycles expected completion", name, cycles);
        end
        checks++;
        if (first_valid != exp_first) begin
            errors++;
            $display("FAIL %s first_valid_cycle: got %0d expected %0d", name, first_valid, exp_first);
        end
        if (abort_after < 0) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s bytes_missing: got %0d left expected 0", name, exp_q.size());
            end
            checks++;
            if (done_cnt != 1) begin
                errors++;
                $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
            end
            checks++;
            if (o_addr !== 15'(exp_last_addr)) begin
                errors++;
                $display("FAIL %s final_rd_addr: got %0h expected %0h", name, o_addr, exp_last_addr);
            end
            checks++;
            if (unstable != 0) begin
                errors++;
                $display("FAIL %s tx_data_stable: got %0d changes expected 0", name, unstable);
            end
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_end: got %b expected 0", name, o_busy);
            end
        end else begin
            checks++;
            if (done_cnt != 0) begin
                errors++;
                $display("FAIL %s abort_done: got %0d pulses expected 0", name, done_cnt);
            end
            checks++;
            if (acks != abort_after) begin
                errors++;
                $display("FAIL %s abort_acks: got %0d expected %0d", name, acks, abort_after);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d: got valid %b busy %b done %b expected 0 0 0",
                         s, o_valid, o_busy, o_done);
            end
            checks++;
            if (o_addr !== 15'd0 || o_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_bus dut%0d: got addr %0h data %02h expected 0 00", s, o_addr, o_data);
            end
            checks++;
            if (o_st !== IDLE) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %0d expected IDLE", s, o_st);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        sel = 0;
        run_dump("full_dump", 0, 0, 2, -1);
    endtask

    task automatic test_wrap();
        sel = 0;
        run_dump("wrap", 'h3FE, 4, -1, -1);
    endtask

    task automatic test_wide_sample();
        sel = 1;
        run_dump("wide_sample", 5, 1, 2, -1);
    endtask

    task automatic test_random_dumps();
        int s_v, l_v;
        sel = 1;
        run_dump("b_full_len0", 9, 0, -1, -1);
        run_dump("b_full_len16", 13, 16, -1, -1);
        for (int i = 0; i < 8; i++) begin
            sel = i % 2;
            s_v = $urandom_range(0, (1 << cur_aw()) - 1);
            l_v = (sel == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(0, 16));
            run_dump("random", s_v, l_v, -1, -1);
        end
    endtask

    task automatic test_abort_restart();
        sel = 1;
        run_dump("abort", $urandom_range(0, 15), 10, -1, 3);
        @(negedge clk);
        run_dump("restart", $urandom_range(0, 15), $urandom_range(1, 12), -1, -1);
    endtask

    task automatic test_reset_mid_dump();
        int cycles, acks, done_seen;
        sel = 0;
        cycles = 0; acks = 0; done_seen = 0;
        @(negedge clk);
        start = 15'h155;
        len   = 16'd40;
        grant = 1'b1;
        while (cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (ack) begin
                ack = 1'b0;
            end else if (o_valid) begin
                if (acks >= 5) break;
                ack = 1'b1;
                acks++;
            end
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid precondition: got valid %b expected 1", o_valid);
        end
        rst_n = 1'b0;
        grant = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid flags: got valid %b busy %b expected 0 0", o_valid, o_busy);
        end
        checks++;
        if (o_addr !== 15'd0 || o_data !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid bus: got addr %0h data %02h expected 0 00", o_addr, o_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (o_done || o_busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_mid after_release: got %0d active cycles expected 0", done_seen);
        end
    endtask

    task automatic test_after_reset();
        sel = 0;
        run_dump("after_reset", $urandom_range(0, 1023), $urandom_range(1, 20), -1, -1);
        sel = 1;
        run_dump("after_reset_b", $urandom_range(0, 15), $urandom_range(1, 6), -1, -1);
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        for (int i = 0; i < (1 << AW_A); i++) ram_a[i] = 8'(i);
        for (int i = 0; i < (1 << AW_B); i++) ram_b[i] = 16'($urandom);
        ram_b[5] = 16'hBEEF;

        test_reset();
        test_full_dump();
        test_wrap();
        test_wide_sample();
        test_random_dumps();
        test_abort_restart();
        test_reset_mid_dump();
        test_after_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_dump_tx

// File: doc/ram_dump_tx.md
Name: ram_dump_tx

Overview:
- Parametrised capture-RAM dump engine: after the arbiter grants the serial transmitter, reads a window of samples from capture RAM and streams them byte-by-byte over the valid/ack byte interface to the UART.
- Generalises the fixed 8-bit / 1024-entry dump with configurable address width, sample width and RAM read latency, plus a start/length window, address wrap and clean abort.
- Pulses done_txd when the dump completes.

Parameters:
- ADDR_W, 10, capture RAM address width; legal range 2..15.
- SAMPLE_W, 8, RAM word width; must be a multiple of 8, at most 64.
- RD_LAT, 1, RAM read latency in cycles from rd_addr to rd_data; legal range 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- grant_txd  in  1  level; transmitter granted to this block; a rise in IDLE starts a dump.
- start_addr  in  ADDR_W  first sample address; sampled on start.
- dump_len  in  ADDR_W+1  number of samples; 0 means full RAM (2^ADDR_W); sampled on start.
- rd_addr  out  ADDR_W  capture RAM read address.
- rd_data  in  SAMPLE_W  capture RAM read data.
- tx_data  out  8  byte to transmit.
- tx_data_valid  out  1  tx_data holds a valid byte.
- tx_data_ack  in  1  one-cycle pulse: UART accepted the byte; ignored unless tx_data_valid is high.
- done_txd  out  1  one-cycle pulse on completion.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; rd_addr 0; tx_data 0; tx_data_valid 0; done_txd 0; busy 0; all counters 0.
- States: IDLE, FETCH, SEND, DONE.
- IDLE: if grant_txd is high, latch start_addr into rd_addr. Latch remaining = (dump_len==0 ? 2^ADDR_W : dump_len). Go to FETCH.
- FETCH: wait RD_LAT cycles, then load rd_data into the shift register and set byte_idx 0. Go to SEND with tx_data_valid high. tx_data_valid therefore rises RD_LAT+1 cycles after grant is sampled.
- SEND: tx_data = shift_reg[7:0], i.e. bytes go out LSB-first. tx_data is stable while valid is high.
- SEND, on ack, not the last byte of the sample: shift right by 8 and increment byte_idx. Valid stays high; the next byte is presented in the next cycle.
- SEND, on ack of the last byte of a sample: decrement remaining. If remaining becomes 0, drop valid and go to DONE. Otherwise increment rd_addr modulo 2^ADDR_W (wrap past the top address to 0), drop valid for the fetch, and go to FETCH.
- DONE: assert done_txd for exactly one cycle, then go to IDLE. A new dump needs grant_txd to be high again in IDLE.
- Abort: grant_txd low in FETCH or SEND → go to IDLE next cycle. tx_data_valid drops; no done_txd pulse. An ack coincident with the grant drop is ignored.
- Reset mid-dump: all outputs return to reset values immediately (asynchronous); no done_txd.
- Byte count per dump is remaining × SAMPLE_W/8. Counters are sized for the full-RAM case with no overflow.

Optional Feature:
- Macro RAM_DUMP_TX_HEADER_EN.
- Defined: before the first sample, send a 4-byte header through the same handshake: 0xA5, 0x5A, then the 16-bit zero-extended sample count, low byte first. The header is sent from a HEADER state entered from IDLE; FETCH follows the 4th ack. Abort rules apply in HEADER.
- Undefined: no header and no HEADER state; samples start immediately.

Decomposition:
- Package la_pkg: state enum type; header constants HDR_SYNC0 = 0xA5 and HDR_SYNC1 = 0x5A; localparam BYTES_PER_SAMPLE = SAMPLE_W/8, computed in-module from its parameter.
- Sub-module sample_serializer: loads a SAMPLE_W word, presents bytes LSB-first under valid/ack, and reports the last byte. The FSM, address and remaining-count logic stay in ram_dump_tx.

Test Plan:
- Defaults, dump_len=0, start_addr=0, RAM[i]=i[7:0], ack 2 cycles after each valid → 1024 bytes 0x00..0xFF repeating, rd_addr ends at 0x3FF, single done_txd pulse.
- start_addr=0x3FE, dump_len=4 → reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap); 4 bytes; done_txd pulses.
- SAMPLE_W=16, RD_LAT=2, RAM[5]=0xBEEF, start=5, len=1 → bytes 0xEF then 0xBE; valid rises 3 cycles after grant.
- grant_txd dropped after 3rd ack of a 10-sample dump → valid low next cycle, busy low, no done_txd; a new grant restarts from the newly sampled start_addr.
- rst_n asserted during SEND → tx_data_valid, busy and rd_addr go to 0 asynchronously; no done_txd after release.
- With RAM_DUMP_TX_HEADER_EN, len=2 → bytes A5, 5A, 02, 00, then sample bytes; done_txd after the last sample byte.
